// File: rtl/cpu_sequencer.sv
// Purpose : instruction-phase sequencer for a simple accumulator CPU; owns a 3-bit phase counter and an IDLE/RUN/HALTED FSM and decodes the datapath controls.
// Latency : controls are combinational on phase/state/opcode/zero; a non-stalled instruction spans 8 cycles (phase 0..7).
// Backpres: mem_ready = 0 in phase 3, or phase 7 for ALU/STO, freezes phase and every output until the first cycle mem_ready = 1.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, resume      one-cycle pulses: leave IDLE / leave HALTED
//   mem_ready          memory handshake (ignored when WAIT_EN = 0)
//   opcode, zero       instruction opcode field and accumulator-zero flag
//   sel .. data_e      datapath control strobes
//   phase, halted      current phase, HALTED indicator
//   illegal            undefined opcode seen in phase 4
module cpu_sequencer #(
    parameter int OPCODE_WIDTH = 3,
    parameter bit WAIT_EN      = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    resume,
    input  logic                    mem_ready,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero,
    output logic                    sel,
    output logic                    rd,
    output logic                    ld_ir,
    output logic                    halt,
    output logic                    inc_pc,
    output logic                    ld_ac,
    output logic                    ld_pc,
    output logic                    wr,
    output logic                    data_e,
    output logic [2:0]              phase,
    output logic                    halted,
    output logic                    illegal
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] phase_q, phase_d;

    // Opcode decode. Widening to 8 bits lets one expression detect codes
    // >= 8 for every legal OPCODE_WIDTH; those decode to nothing (NOP).
    logic [7:0] op_ext;
    logic       op_def;
    logic       is_hlt, is_skz, is_sto, is_jmp, is_alu;
    logic       mem_rdy;
    logic       stall;

    assign op_ext  = 8'(opcode);
    assign op_def  = (op_ext[7:3] == 5'd0);
    assign is_hlt  = op_def && (op_ext[2:0] == 3'd0);
    assign is_skz  = op_def && (op_ext[2:0] == 3'd1);
    assign is_alu  = op_def && (op_ext[2:0] >= 3'd2) && (op_ext[2:0] <= 3'd5);
    assign is_sto  = op_def && (op_ext[2:0] == 3'd6);
    assign is_jmp  = op_def && (op_ext[2:0] == 3'd7);

    assign mem_rdy = WAIT_EN ? mem_ready : 1'b1;

    // Phase 3 is the instruction fetch; phase 7 is the operand read/write.
    assign stall = (state_q == S_RUN) && !mem_rdy &&
                   ((phase_q == 3'd3) || ((phase_q == 3'd7) && (is_alu || is_sto)));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= 3'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            S_IDLE: begin
                phase_d = 3'd0;
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if ((phase_q == 3'd4) && is_hlt) begin
                    // Phase stays at 4 while halted; resume continues at 5.
                    state_d = S_HALTED;
                end else if (!stall) begin
                    phase_d = phase_q + 3'd1;
                end
            end
            S_HALTED: begin
                if (resume) begin
                    state_d = S_RUN;
                    phase_d = 3'd5;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = 3'd0;
            end
        endcase
    end

    // Output decode
    always_comb begin
        sel     = 1'b0;
        rd      = 1'b0;
        ld_ir   = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        ld_ac   = 1'b0;
        ld_pc   = 1'b0;
        wr      = 1'b0;
        data_e  = 1'b0;
        halted  = 1'b0;
        illegal = 1'b0;
        case (state_q)
            S_RUN: begin
                case (phase_q)
                    3'd0, 3'd1: begin
                        sel = 1'b1;
                        rd  = 1'b1;
                    end
                    3'd2, 3'd3: begin
                        sel   = 1'b1;
                        rd    = 1'b1;
                        ld_ir = 1'b1;
                    end
                    3'd4: begin
                        inc_pc  = 1'b1;
                        halt    = is_hlt;
                        illegal = !op_def;
                    end
                    3'd5: begin
                        rd = is_alu;
                    end
                    3'd6: begin
                        rd     = is_alu;
                        inc_pc = is_skz && zero;
                        ld_pc  = is_jmp;
                        data_e = is_sto;
                    end
                    default: begin
                        rd     = is_alu;
                        ld_ac  = is_alu;
                        ld_pc  = is_jmp;
                        wr     = is_sto;
                        data_e = is_sto;
                    end
                endcase
            end
            S_HALTED: begin
                halt   = 1'b1;
                halted = 1'b1;
            end
            default: ;
        endcase
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer (OPCODE_WIDTH = 4 so undefined opcodes are reachable).
// A behavioural model tracks mode/phase from the instruction-level rules and a
// negedge process compares all outputs every cycle; directed sections pin the
// model with literal expectations before a randomized run.
module tb_cpu_sequencer;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       resume = 1'b0;
    logic       mem_ready = 1'b1;
    logic [3:0] opcode = 4'd0;
    logic       zero = 1'b0;
    logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
    logic [2:0] phase;
    logic       halted, illegal;

    int n_pass  = 0;
    int n_total = 0;

    int m_mode = M_IDLE;
    int m_ph   = 0;

    cpu_sequencer #(.OPCODE_WIDTH(4), .WAIT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .resume(resume),
        .mem_ready(mem_ready), .opcode(opcode), .zero(zero),
        .sel(sel), .rd(rd), .ld_ir(ld_ir), .halt(halt), .inc_pc(inc_pc),
        .ld_ac(ld_ac), .ld_pc(ld_pc), .wr(wr), .data_e(data_e),
        .phase(phase), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs from the instruction-level control table.
    function automatic logic [13:0] expect_out(input int mode, input int ph, input int op, input bit z);
        bit run  = (mode == M_RUN);
        bit hlt  = (op == 0);
        bit skz  = (op == 1);
        bit alu  = (op >= 2) && (op <= 5);
        bit sto  = (op == 6);
        bit jmp  = (op == 7);
        bit e_sel  = run && (ph <= 3);
        bit e_rd   = run && ((ph <= 3) || ((ph >= 5) && alu));
        bit e_ldir = run && ((ph == 2) || (ph == 3));
        bit e_halt = (mode == M_HALT) || (run && (ph == 4) && hlt);
        bit e_inc  = run && ((ph == 4) || ((ph == 6) && skz && z));
        bit e_ldac = run && (ph == 7) && alu;
        bit e_ldpc = run && ((ph == 6) || (ph == 7)) && jmp;
        bit e_wr   = run && (ph == 7) && sto;
        bit e_de   = run && ((ph == 6) || (ph == 7)) && sto;
        bit e_hd   = (mode == M_HALT);
        bit e_il   = run && (ph == 4) && (op > 7);
        return {e_sel, e_rd, e_ldir, e_halt, e_inc, e_ldac, e_ldpc, e_wr, e_de,
                3'(ph), e_hd, e_il};
    endfunction

    // Model state advance
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= M_IDLE;
            m_ph   <= 0;
        end else begin
            int  op;
            bit  waits;
            op    = int'(opcode);
            waits = !mem_ready && ((m_ph == 3) ||
                    ((m_ph == 7) && (((op >= 2) && (op <= 5)) || (op == 6))));
            if (m_mode == M_IDLE) begin
                if (start) begin
                    m_mode <= M_RUN;
                    m_ph   <= 0;
                end
            end else if (m_mode == M_RUN) begin
                if ((m_ph == 4) && (op == 0)) m_mode <= M_HALT;
                else if (!waits) m_ph <= (m_ph + 1) % 8;
            end else if (resume) begin
                m_mode <= M_RUN;
                m_ph   <= 5;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        check("model_cycle",
              int'({sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, phase, halted, illegal}),
              int'(expect_out(m_mode, m_ph, int'(opcode), zero)));
    end

    initial begin
        logic [7:0] rd_pat;
        logic [7:0] ldac_pat;
        int cnt;
        int bad;
        int il_ph;
        rd_pat   = 8'b1110_1111;
        ldac_pat = 8'b1000_0000;

        // Reset state
        #12;
        check("reset_phase", int'(phase), 0);
        check("reset_outs", int'({sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, halted, illegal}), 0);
        rst_n = 1'b1;
        step();
        check("idle_after_reset", int'(phase), 0);

        // ADD: 8 phases, rd/ld_ac pattern, then wrap
        start = 1'b1; opcode = 4'd2; mem_ready = 1'b1;
        @(negedge clk);
        check("idle_before_start", int'(sel), 0);
        step();
        start = 1'b0;
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            check("add_phase", int'(phase), p);
            check("add_rd", int'(rd), int'(rd_pat[p]));
            check("add_ld_ac", int'(ld_ac), int'(ldac_pat[p]));
            step();
        end
        check("add_wrap", int'(phase), 0);

        // SKZ: inc_pc pulses per instruction
        opcode = 4'd1; zero = 1'b1; cnt = 0;
        for (int p = 0; p < 8; p++) begin
            @(negedge clk); cnt += int'(inc_pc); step();
        end
        check("skz_zero1_incpc", cnt, 2);
        zero = 1'b0; cnt = 0;
        for (int p = 0; p < 8; p++) begin
            @(negedge clk); cnt += int'(inc_pc); step();
        end
        check("skz_zero0_incpc", cnt, 1);

        // STO with 3 stall cycles at phase 7: 11-cycle instruction
        opcode = 4'd6; cnt = 0;
        for (int c = 0; c < 11; c++) begin
            mem_ready = !((c >= 7) && (c <= 9));
            @(negedge clk);
            if (wr && data_e && (phase == 3'd7)) cnt++;
            step();
        end
        mem_ready = 1'b1;
        check("sto_wr_hold", cnt, 4);
        check("sto_len_phase", int'(phase), 0);

        // HLT: halt at phase 4, then HALTED until resume
        opcode = 4'd0;
        for (int p = 0; p < 4; p++) step();
        @(negedge clk);
        check("hlt_p4_halt", int'(halt), 1);
        check("hlt_p4_halted", int'(halted), 0);
        step();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("halted_flag", int'(halted), 1);
            check("halted_phase", int'(phase), 4);
            check("halted_inc_pc", int'(inc_pc), 0);
            step();
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("resume_phase", int'(phase), 5);
        check("resume_halted", int'(halted), 0);
        for (int p = 0; p < 3; p++) step();
        check("resume_wrap", int'(phase), 0);

        // Undefined opcode 9
        opcode = 4'd9; cnt = 0; bad = 0; il_ph = -1;
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            if (illegal) begin cnt++; il_ph = int'(phase); end
            if (phase >= 3'd5) bad += int'(rd | ld_ac | ld_pc | wr);
            step();
        end
        check("illegal_count", cnt, 1);
        check("illegal_phase", il_ph, 4);
        check("illegal_nop", bad, 0);

        // Async reset while stalled at phase 3
        opcode = 4'd2;
        for (int p = 0; p < 3; p++) step();
        mem_ready = 1'b0;
        step();
        @(negedge clk);
        check("stall_p3_hold", int'(phase), 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_phase", int'(phase), 0);
        check("async_rst_outs", int'({sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, halted, illegal}), 0);
        step();
        rst_n = 1'b1; mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) step();
        @(negedge clk);
        check("post_rst_idle_sel", int'(sel), 0);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        check("restart_sel", int'(sel), 1);
        step();

        // Randomized run
        for (int c = 0; c < 4000; c++) begin
            start     = ($urandom_range(0, 7) == 0);
            resume    = ($urandom_range(0, 3) == 0);
            mem_ready = ($urandom_range(0, 9) < 7);
            zero      = 1'($urandom_range(0, 1));
            if ((m_mode == M_IDLE) || ((m_mode == M_RUN) && (m_ph <= 3)))
                opcode = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter OPCODE_WIDTH, default 3, opcode bus width; legal values 3..8.
REQ-002 Parameter WAIT_EN, default 1, enables memory-ready stalls; 0 ties mem_ready internally to 1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that launches execution from IDLE.
REQ-006 resume  input  1  one-cycle pulse that leaves HALTED.
REQ-007 mem_ready  input  1  memory handshake; 1 = current access completes this cycle.
REQ-008 opcode  input  OPCODE_WIDTH  instruction register opcode field.
REQ-009 zero  input  1  accumulator-zero flag.
REQ-010 sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e  output  1 each  datapath controls.
REQ-011 phase  output  3  current phase counter value.
REQ-012 halted  output  1  1 while in the HALTED state.
REQ-013 illegal  output  1  1 during phase 4 when opcode is not defined.

Function
REQ-014 The block SHALL own a 3-bit phase counter and a 3-state FSM {IDLE, RUN, HALTED}.
- Control outputs are combinational decodes of phase, state, opcode and zero.
REQ-015 Opcode decode:
- 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
- ALU = ADD | AND | XOR | LDA.
- Values 8 and above (OPCODE_WIDTH > 3) are undefined: they behave as NOP with no control asserted in phases 5-7, and illegal = 1 in phase 4.
REQ-016 RUN decode; unlisted outputs are 0:
- Phases 0-1: sel, rd.
- Phases 2-3: sel, rd, ld_ir.
- Phase 4: inc_pc; halt = HLT.
- Phase 5: rd = ALU.
- Phase 6: rd = ALU; inc_pc = SKZ & zero; ld_pc = JMP; data_e = STO.
- Phase 7: rd = ALU; ld_ac = ALU; ld_pc = JMP; wr = STO; data_e = STO.
REQ-017 In IDLE, all control outputs SHALL be 0 and phase SHALL be 0.
REQ-018 IDLE to RUN SHALL occur on the edge where start = 1; phase 0 is decoded on the following cycle.
REQ-019 In RUN, phase SHALL increment by 1 per cycle, wrapping from 7 to 0, unless stalled or halting.
REQ-020 Stall rules:
- A stall SHALL occur when mem_ready = 0 and the current phase is 3, or phase 7 with ALU or STO.
- During a stall, phase and all outputs SHALL hold unchanged.
- Advance SHALL occur on the first edge where mem_ready = 1.
REQ-021 Halt entry:
- Phase 4 with HLT SHALL assert halt for one cycle.
- On that edge, the FSM SHALL enter HALTED with phase frozen at 4.
REQ-022 In HALTED:
- halt and halted SHALL be 1 and all other controls 0.
- On the edge where resume = 1, the FSM SHALL enter RUN with phase 5.
REQ-023 start outside IDLE and resume outside HALTED SHALL be ignored.
REQ-024 zero SHALL be used only in phase 6; changes in other phases have no effect.
REQ-025 Latency:
- A non-stalled instruction takes exactly 8 cycles, phase 0 to phase 7.
- Each stall cycle adds exactly 1 cycle.
REQ-026 Opcode SHALL be treated as stable from phase 4 to 7; the block SHALL NOT register opcode.

Reset
REQ-027 rst_n = 0 SHALL immediately, without waiting for clk, force:
- state IDLE, phase 0, all control outputs 0, halted 0, illegal 0.
REQ-028 Reset asserted mid-stall or in HALTED SHALL behave identically to REQ-027.
REQ-029 After rst_n rises, the block SHALL remain in IDLE until a start pulse.

Verification
REQ-030 Reset, start, opcode ADD, mem_ready = 1 -> phase 0..7 over 8 cycles; ld_ac = 1 only in phase 7; rd = 1 in phases 0-3 and 5-7; then wraps to phase 0.
REQ-031 Opcode SKZ -> inc_pc in phase 6 equals zero: zero = 1 gives two inc_pc pulses per instruction, zero = 0 gives one (phase 4 only).
REQ-032 Opcode STO, mem_ready = 0 for 3 cycles at phase 7 -> wr = data_e = 1 held 4 cycles with phase = 7; instruction takes 11 cycles.
REQ-033 Opcode HLT -> halt = 1 at phase 4, then halted = 1 with phase = 4 indefinitely; a resume pulse gives phase 5 on the next cycle and halted = 0.
REQ-034 OPCODE_WIDTH = 4, opcode 9 -> illegal = 1 in phase 4 only; no rd, ld_ac, ld_pc or wr in phases 5-7.
REQ-035 rst_n pulled low asynchronously while stalled at phase 3 -> all outputs 0 and phase 0 before the next clk edge; start is required to restart.
